// File: rtl/perceptron_pkg.sv
// Shared types and widths for the perceptron classifier and its arbiter.
// Holds the FSM state encoding, feature widths and the feature-sum helper.
// No logic of its own; imported by every file of this block.
package perceptron_pkg;

    localparam int EDGE_W  = 3;
    localparam int CURVE_W = 4;
    localparam int CLASS_W = 4;
    localparam int SUM_W   = 8;
    localparam int CNT_W   = 8;

    localparam logic [CLASS_W-1:0] CLASS_UNKNOWN = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Weighted feature sum: 2*edges + 8*curves, never exceeds 134.
    function automatic logic [SUM_W-1:0] feature_sum(
        input logic [EDGE_W-1:0]  edges,
        input logic [CURVE_W-1:0] curves
    );
        return {4'b0000, edges, 1'b0} + {1'b0, curves, 3'b000};
    endfunction

endpackage

// File: rtl/perceptron_arbiter_if.sv
// Requester bank plus response channel between front ends and the arbiter.
// master = requesters/consumer side, slave = arbiter side.
// Valid/ready on both the request bank and the response channel.
interface perceptron_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
    import perceptron_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [EDGE_W*NUM_REQ-1:0]  req_edges;
    logic [CURVE_W*NUM_REQ-1:0] req_curves;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [CLASS_W-1:0]         rsp_class;
    logic [ID_W-1:0]            rsp_id;

    modport master (
        output req_valid, req_edges, req_curves, rsp_ready,
        input  req_ready, rsp_valid, rsp_class, rsp_id
    );

    modport slave (
        input  req_valid, req_edges, req_curves, rsp_ready,
        output req_ready, rsp_valid, rsp_class, rsp_id
    );

endinterface

// File: rtl/perceptron.sv
// Combinational digit classifier mapping (edges, curves) to a 4-bit class.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows the inputs.
module perceptron
    import perceptron_pkg::*;
(
    input  logic [EDGE_W-1:0]  edges,
    input  logic [CURVE_W-1:0] curves,
    output logic [CLASS_W-1:0] class_out
);

    logic [SUM_W-1:0] sum;

    assign sum = feature_sum(edges, curves);

    always_comb begin
        class_out = CLASS_UNKNOWN;
        case (sum)
            8'd32:   class_out = 4'd0;
            8'd2:    class_out = 4'd1;
            8'd20:   class_out = 4'd2;
            8'd34:   class_out = 4'd3;
            8'd6:    class_out = 4'd4;
            8'd28:   class_out = 4'd5;
            8'd40:   class_out = 4'd6;
            8'd4:    class_out = 4'd7;
            8'd64:   class_out = 4'd8;
            8'd26:   class_out = 4'd9;
            default: class_out = CLASS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/perceptron_arbiter.sv
// Round-robin sharing of one perceptron between NUM_REQ feature requesters.
// Latency: request accepted in cycle T -> rsp_valid in T+2; one sample per 3 cycles.
// Backpressure: RESP holds class/id until rsp_ready; no new grant meanwhile.
module perceptron_arbiter
    import perceptron_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    perceptron_arbiter_if.slave bus,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    reject_cnt
);

    state_t             state;
    logic [EDGE_W-1:0]  op_edges;
    logic [CURVE_W-1:0] op_curves;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant;
    logic               grant_vld;
    logic [EDGE_W-1:0]  sel_edges;
    logic [CURVE_W-1:0] sel_curves;
    logic [CLASS_W-1:0] eval_class;
    logic [CLASS_W-1:0] rsp_class_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_valid_q;
    logic               rsp_hs;

    // First valid requester found after the previous winner, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] vld,
        input logic [ID_W-1:0]    last
    );
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(last) + i) % NUM_REQ;
            cand = ID_W'(idx);
            if (!found && vld[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        grant      = rr_pick(bus.req_valid, last_grant);
        grant_vld  = (state == IDLE) && (|bus.req_valid);
        sel_edges  = '0;
        sel_curves = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_edges  = bus.req_edges[EDGE_W*i +: EDGE_W];
                sel_curves = bus.req_curves[CURVE_W*i +: CURVE_W];
            end
        end
        bus.req_ready = '0;
        if (grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    perceptron u_perceptron (
        .edges     (op_edges),
        .curves    (op_curves),
        .class_out (eval_class)
    );

    assign rsp_hs = rsp_valid_q && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_edges    <= '0;
            op_curves   <= '0;
            op_id       <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            rsp_class_q <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            reject_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_edges   <= sel_edges;
                        op_curves  <= sel_curves;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_class_q <= eval_class;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase

            // Clear wins over a same-cycle reject; the count sticks at all-ones.
            if (cnt_clr) begin
                reject_cnt <= '0;
            end else if (rsp_hs && (rsp_class_q == CLASS_UNKNOWN) && (reject_cnt != '1)) begin
                reject_cnt <= reject_cnt + 1'b1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_class = rsp_class_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_perceptron_arbiter.sv
// Self-checking bench for perceptron_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_perceptron_arbiter;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int EW  = 3 * N;
    localparam int CW  = 4 * N;

    logic       clk;
    logic       rst;
    logic       cnt_clr;
    logic [7:0] reject_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int last_g;

    perceptron_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    perceptron_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .reject_cnt (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Class lookup straight from the digit table.
    function automatic int model_class(input int e, input int c);
        int tbl[10] = '{32, 2, 20, 34, 6, 28, 40, 4, 64, 26};
        int s;
        s = 2 * e + 8 * c;
        for (int k = 0; k < 10; k++) if (tbl[k] == s) return k;
        return 15;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input int e, input int c);
        bus.req_edges[3*i +: 3]  = 3'(e);
        bus.req_curves[4*i +: 4] = 4'(c);
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; cnt_clr = 1'b0;
        bus.req_valid = '0; bus.req_edges = '0; bus.req_curves = '0; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_g = N - 1;
    endtask

    // Hold current requests; return once n responses have been handshaken.
    task automatic run_rsp(input int n, output int got);
        got = 0;
        for (int c = 0; c < n * 3 + 10 && got < n; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) got++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_class !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_class: got %h want 0", bus.rsp_class); end
        n_checks++; if (bus.rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        n_checks++; if (reject_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_reject_cnt: got %0d want 0", reject_cnt); end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ignored: rsp_valid got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_single;
        do_reset;
        set_req(0, 1, 0); bus.req_valid = N'(1); bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== N'(1)) begin n_fail++; $display("FAIL single_grant: got %b want %b", bus.req_ready, N'(1)); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_t1_valid: got %b want 0", bus.rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_t2_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_class !== 4'(model_class(1, 0))) begin n_fail++; $display("FAIL single_class: got %0d want %0d", bus.rsp_class, model_class(1, 0)); end
        n_checks++; if (bus.rsp_id !== IDW'(0)) begin n_fail++; $display("FAIL single_id: got %0d want 0", bus.rsp_id); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_hs: rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (reject_cnt !== 8'd0) begin n_fail++; $display("FAIL single_reject_cnt: got %0d want 0", reject_cnt); end
    endtask

    task automatic test_round_robin;
        int q_cls[$];
        int q_id[$];
        int ng, nr, prev, g, ec, ei;
        do_reset;
        set_req(0, 0, 4); set_req(1, 2, 2);
        bus.req_valid = N'(3); bus.rsp_ready = 1'b1;
        ng = 0; nr = 0; prev = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready !== '0) begin
                g = ng % 2;
                n_checks++; if (bus.req_ready !== N'(1 << g)) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", ng, bus.req_ready, N'(1 << g)); end
                if (ng > 0) begin
                    n_checks++; if (c - prev !== 3) begin n_fail++; $display("FAIL rr_spacing: got %0d cycles want 3", c - prev); end
                end
                prev = c;
                q_cls.push_back(model_class(int'(bus.req_edges[3*g +: 3]), int'(bus.req_curves[4*g +: 4])));
                q_id.push_back(g);
                ng++;
            end
            if (bus.rsp_valid === 1'b1) begin
                ec = (q_cls.size() > 0) ? q_cls.pop_front() : -1;
                ei = (q_id.size() > 0) ? q_id.pop_front() : -1;
                n_checks++; if (int'(bus.rsp_class) !== ec || int'(bus.rsp_id) !== ei) begin n_fail++; $display("FAIL rr_rsp[%0d]: got class %0d id %0d want class %0d id %0d", nr, bus.rsp_class, bus.rsp_id, ec, ei); end
                nr++;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        n_checks++; if (ng !== 4 || nr !== 4) begin n_fail++; $display("FAIL rr_counts: got %0d grants %0d rsps want 4 and 4", ng, nr); end
    endtask

    task automatic test_backpressure;
        do_reset;
        set_req(1, 1, 4); bus.req_valid = N'(2); bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== N'(2)) begin n_fail++; $display("FAIL bp_grant: got %b want %b", bus.req_ready, N'(2)); end
        @(posedge clk); #1;
        set_req(0, 0, 8); bus.req_valid = N'(1);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL bp_eval_ready: got %b want 0", bus.req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_class !== 4'(model_class(1, 4)) || bus.rsp_id !== IDW'(1)) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v%b class %0d id %0d want v1 class %0d id 1", k, bus.rsp_valid, bus.rsp_class, bus.rsp_id, model_class(1, 4)); end
            n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", k, bus.req_ready); end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hs_cycle: got ready %b valid %b want 0 and 1", bus.req_ready, bus.rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== N'(1)) begin n_fail++; $display("FAIL bp_next_grant: got %b want %b", bus.req_ready, N'(1)); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_class !== 4'(model_class(0, 8)) || bus.rsp_id !== IDW'(0)) begin
            n_fail++; $display("FAIL bp_second_rsp: got v%b class %0d id %0d want v1 class %0d id 0", bus.rsp_valid, bus.rsp_class, bus.rsp_id, model_class(0, 8)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reject_cnt;
        int got;
        logic found;
        do_reset;
        set_req(0, 7, 0); bus.req_valid = N'(1); bus.rsp_ready = 1'b1;
        run_rsp(3, got);
        bus.req_valid = '0;
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL rej_three_hs: got %0d want 3", got); end
        @(negedge clk);
        n_checks++; if (reject_cnt !== 8'd3) begin n_fail++; $display("FAIL rej_count3: got %0d want 3", reject_cnt); end
        @(posedge clk); #1;
        bus.req_valid = N'(1);
        run_rsp(255, got);
        n_checks++; if (got !== 255) begin n_fail++; $display("FAIL rej_many_hs: got %0d want 255", got); end
        @(negedge clk);
        n_checks++; if (reject_cnt !== 8'd255) begin n_fail++; $display("FAIL rej_saturate: got %0d want 255", reject_cnt); end
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) found = 1'b1;
        end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0; bus.req_valid = '0;
        @(negedge clk);
        n_checks++; if (!found || reject_cnt !== 8'd0) begin n_fail++; $display("FAIL rej_clr_wins: found %b count %0d want 1 and 0", found, reject_cnt); end
        @(posedge clk); #1;
        bus.req_valid = N'(1);
        run_rsp(1, got);
        bus.req_valid = '0;
        @(negedge clk);
        n_checks++; if (reject_cnt !== 8'd1) begin n_fail++; $display("FAIL rej_after_clr: got %0d want 1", reject_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int stale;
        do_reset;
        set_req(0, 0, 8); bus.req_valid = N'(1); bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== N'(1)) begin n_fail++; $display("FAIL rstmid_grant: got %b want %b", bus.req_ready, N'(1)); end
        @(posedge clk); #1;
        bus.req_valid = '0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; last_g = N - 1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin n_fail++; $display("FAIL rstmid_after: got valid %b ready %b want 0 0", bus.rsp_valid, bus.req_ready); end
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d stale cycles want 0", stale); end
        @(posedge clk); #1;
        bus.req_valid = N'(1);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== N'(1)) begin n_fail++; $display("FAIL rstmid_regrant: got %b want %b", bus.req_ready, N'(1)); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_class !== 4'd8 || bus.rsp_id !== IDW'(0)) begin
            n_fail++; $display("FAIL rstmid_rsp: got v%b class %0d id %0d want v1 class 8 id 0", bus.rsp_valid, bus.rsp_class, bus.rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic       busy, hs, due_now;
        int         due, g, ecls, eid, mcnt;
        logic [N-1:0] exp_rdy;
        do_reset;
        busy = 1'b0; due = 0; ecls = 0; eid = 0; mcnt = 0;
        for (int c = 0; c < 400; c++) begin
            bus.req_valid  = N'($urandom);
            bus.req_edges  = EW'($urandom);
            bus.req_curves = CW'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            cnt_clr        = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            g       = busy ? -1 : model_pick(bus.req_valid, last_g);
            exp_rdy = (g < 0) ? '0 : N'(1 << g);
            due_now = busy && (c >= due);
            n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
            n_checks++; if (bus.rsp_valid !== due_now) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.rsp_valid, due_now); end
            if (due_now) begin
                n_checks++; if (int'(bus.rsp_class) !== ecls || int'(bus.rsp_id) !== eid) begin
                    n_fail++; $display("FAIL rand_rsp c%0d: got class %0d id %0d want class %0d id %0d", c, bus.rsp_class, bus.rsp_id, ecls, eid); end
            end
            n_checks++; if (int'(reject_cnt) !== mcnt) begin n_fail++; $display("FAIL rand_reject_cnt c%0d: got %0d want %0d", c, reject_cnt, mcnt); end
            hs = due_now && bus.rsp_ready;
            if (cnt_clr) mcnt = 0;
            else if (hs && ecls == 15 && mcnt < 255) mcnt++;
            if (hs) busy = 1'b0;
            if (g >= 0) begin
                busy = 1'b1; due = c + 2; eid = g; last_g = g;
                ecls = model_class(int'(bus.req_edges[3*g +: 3]), int'(bus.req_curves[4*g +: 4]));
            end
            @(posedge clk); #1;
        end
        cnt_clr = 1'b0; bus.req_valid = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cnt_clr = 1'b0;
        bus.req_valid = '0; bus.req_edges = '0; bus.req_curves = '0; bus.rsp_ready = 1'b0;
        last_g = N - 1;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_reject_cnt;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_arbiter.md
# perceptron_arbiter

Round-robin arbiter and sequencer that shares one combinational `perceptron` digit classifier between `NUM_REQ` feature requesters. It registers each granted (edges, curves) sample, evaluates it for one cycle, and returns the 4-bit class with the requester ID over a valid/ready response channel. It also keeps a saturating count of unclassified results (class 4'hF). It sits between the feature-extraction front ends and the tile output logic.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width; minimum 1.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req_valid` input `NUM_REQ`: per-requester sample valid.
- `req_ready` output `NUM_REQ`: per-requester accept; at most one bit is high (one-hot or zero).
- `req_edges` input `3*NUM_REQ`: packed edge counts; requester i occupies bits [3i+2:3i].
- `req_curves` input `4*NUM_REQ`: packed curve counts; requester i occupies bits [4i+3:4i].
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response accepted by the consumer.
- `rsp_class` output 4: classifier result.
- `rsp_id` output `ID_W`: index of the requester that owns the response.
- `cnt_clr` input 1: clears `reject_cnt`.
- `reject_cnt` output 8: saturating count of delivered responses with class 4'hF.

## Operation
- State machine states are IDLE, EVAL and RESP.
- **IDLE**
  - If any `req_valid` bit is set, select grant g by round-robin, searching from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready[g]` = 1 combinationally. No other `req_ready` bit is high.
  - Capture edges into `op_edges`, curves into `op_curves`, and g into `op_id`.
  - Set `last_grant <= g` and move to EVAL.
  - If no `req_valid` bit is set, stay in IDLE; `req_ready` = 0.
- **EVAL**
  - The `perceptron` is driven from `op_edges` and `op_curves`.
  - Its output is registered into `rsp_class`, and `op_id` into `rsp_id`.
  - Move to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_class` and `rsp_id` are held stable until `rsp_ready` = 1.
  - On the handshake, move to IDLE.
- In EVAL and RESP, `req_ready` = 0.
- Requesters may drop `req_valid` before they are granted. Sample data is used only on a handshake cycle.
- **Classifier function** (sum is 8 bits; maximum 134, no overflow): sum = 2*edges + 8*curves. Class map:
  - 32→0, 2→1, 20→2, 34→3, 6→4, 28→5, 40→6, 4→7, 64→8, 26→9.
  - Any other sum → 4'hF.
- **reject_cnt**
  - Increments by 1 on a response handshake with `rsp_class` == 4'hF.
  - Saturates at 255.
  - If `cnt_clr` = 1, the next value is 0; this overrides a simultaneous increment.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 0.
  - `rsp_valid` = 0, `rsp_class` = 4'h0, `rsp_id` = 0.
  - `reject_cnt` = 0.
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins the first arbitration.
- Latency: request handshake in cycle T gives `rsp_valid` high in cycle T+2.
- Throughput: with `rsp_ready` held high, one sample per 3 cycles.
- Backpressure: RESP holds indefinitely while `rsp_ready` = 0. No new grant is made during that time.
- Reset mid-operation: any captured sample or pending response is discarded. Nothing is emitted after reset.
- `rsp_ready` asserted while `rsp_valid` = 0 is ignored.

## Structure
- Shared package `perceptron_pkg` holds:
  - `CLASS_UNKNOWN` = 4'hF.
  - The state enum (IDLE, EVAL, RESP).
  - Feature widths: `EDGE_W` = 3, `CURVE_W` = 4, `CLASS_W` = 4.
- Sub-module: exactly one instance of the existing `perceptron` module, unchanged.
- The round-robin picker is a function or an always block inside this module, not a separate module.

## Test plan
- **Single request.** After reset, req 0 sends edges = 1, curves = 0, with `rsp_ready` = 1.
  - `req_ready[0]` is high in cycle T.
  - `rsp_valid` is high at T+2, with class 1 and ID 0.
  - `reject_cnt` stays 0.
- **Round-robin.** Both requesters hold valid: req0 (0,4) and req1 (2,2).
  - Grant order is 0, 1, 0, 1.
  - Responses are class 0/ID 0 and class 2/ID 1, alternating.
- **Backpressure.** Req 1 sends (1,4) with `rsp_ready` held 0 for 5 cycles.
  - `rsp_valid` stays high with class 3 and ID 1 held stable throughout.
  - `req_ready` stays 0 while stalled.
  - The next grant happens only after the handshake.
- **Reject counter.** Send (7,0) three times, giving sum 14 and class 4'hF each time; `reject_cnt` reaches 3.
  - Force the count to 255; it saturates there.
  - `cnt_clr` asserted together with an increment gives 0.
- **Reset mid-operation.** Assert `rst` in EVAL.
  - On the next cycle `rsp_valid` = 0 and state is IDLE.
  - No stale response appears.
  - A following request from req 0 (0,8) returns class 8.
